// File: rtl/eep_spi_pkg.sv
// rtl/eep_spi_pkg.sv - shared frame fields, opcodes and FSM states for the EEPROM SPI responder
package eep_spi_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int FRM_W  = 16;
    localparam int CNT_W  = 5;

    localparam logic [1:0] EEP_WR = 2'b01;
    localparam logic [1:0] EEP_RD = 2'b00;

    localparam logic [CNT_W-1:0] FRM_BITS = CNT_W'(FRM_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/eep_spi_if.sv
// rtl/eep_spi_if.sv - SPI pins and frame-status outputs of the EEPROM responder
interface eep_spi_if;
    import eep_spi_pkg::*;

    logic             SCLK;
    logic             MOSI;
    logic             EEP_ss_n;
    logic             frm_rdy;
    logic [FRM_W-1:0] rx_data;

    modport master (output SCLK, MOSI, EEP_ss_n, input frm_rdy, rx_data);
    modport slave  (input SCLK, MOSI, EEP_ss_n, output frm_rdy, rx_data);

endinterface

// File: rtl/eep_spi_resp_sync_edge.sv
// rtl/eep_spi_resp_sync_edge.sv - two-flop synchronizer with registered-history rise/fall pulses
module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, prev_q;

    // Resets low: a select held low through reset must not look like a fresh fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~prev_q;
    assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/eep_spi_resp.sv
// rtl/eep_spi_resp.sv - SPI slave for the 64x8 calibration EEPROM; read data returns in the following frame
module eep_spi_resp
    import eep_spi_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT_VAL = 8'h00
) (
    input  logic      clk,
    input  logic      rst_n,
    eep_spi_if.slave  bus,
    output wire       MISO
);

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic mosi_s1_q, mosi_s2_q;

    spi_sync_edge u_sclk (.clk(clk), .rst_n(rst_n), .d_i(bus.SCLK),
                          .rise_o(sclk_rise), .fall_o(sclk_fall));
    spi_sync_edge u_ss   (.clk(clk), .rst_n(rst_n), .d_i(bus.EEP_ss_n),
                          .rise_o(ss_rise), .fall_o(ss_fall));

    state_t                  state_q, state_d;
    logic [FRM_W-1:0]        tx_q, tx_d, rx_q, rx_d, resp_q, resp_d, rx_data_q, rx_data_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    frm_rdy_q;
    logic [DATA_W-1:0]       mem_q [2**ADDR_W];
    logic                    load_tx, shift_rx, shift_tx, exec, mem_we;
    logic [1:0]              op;
    logic [ADDR_W-1:0]       addr;
    logic [DATA_W-1:0]       wdata;

    assign op    = rx_q[FRM_W-1 -: 2];
    assign addr  = rx_q[DATA_W +: ADDR_W];
    assign wdata = rx_q[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ss_fall) state_d = SHIFT;
            SHIFT:   if (ss_rise) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A select rise masks any SCLK edge in the same cycle.
    always_comb begin
        load_tx  = 1'b0;
        shift_rx = 1'b0;
        shift_tx = 1'b0;
        exec     = 1'b0;
        unique case (state_q)
            IDLE:  load_tx = ss_fall;
            SHIFT: if (!ss_rise) begin
                       shift_rx = sclk_rise && (cnt_q != FRM_BITS);
                       shift_tx = sclk_fall;
                   end
            DONE:  exec = (cnt_q == FRM_BITS);
            default: ;
        endcase
    end

    assign mem_we = exec && (op == EEP_WR);

    always_comb begin
        tx_d      = tx_q;
        rx_d      = rx_q;
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        rx_data_d = rx_data_q;
        if (load_tx) begin
            tx_d  = resp_q;
            cnt_d = '0;
        end else if (shift_tx) begin
            tx_d = {tx_q[FRM_W-2:0], 1'b0};
        end
        if (shift_rx) begin
            rx_d  = {rx_q[FRM_W-2:0], mosi_s2_q};
            cnt_d = cnt_q + 1'b1;
        end
        if (exec) begin
            rx_data_d = rx_q;
            resp_d    = (op == EEP_RD) ? {{(FRM_W-DATA_W){1'b0}}, mem_q[addr]} : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            cnt_q     <= '0;
            resp_q    <= '0;
            rx_data_q <= '0;
            frm_rdy_q <= 1'b0;
            for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= INIT_VAL;
        end else begin
            mosi_s1_q <= bus.MOSI;
            mosi_s2_q <= mosi_s1_q;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            rx_data_q <= rx_data_d;
            frm_rdy_q <= exec;
            if (mem_we) mem_q[addr] <= wdata;
        end
    end

    assign bus.frm_rdy = frm_rdy_q;
    assign bus.rx_data = rx_data_q;
    assign MISO        = bus.EEP_ss_n ? 1'bz : tx_q[FRM_W-1];

endmodule

// File: tb/tb_eep_spi_resp.sv
// tb/tb_eep_spi_resp.sv - directed frames against a behavioural EEPROM model with per-cycle output compare
module tb_eep_spi_resp;

    localparam logic [7:0] INIT = 8'h00;

    logic clk = 1'b0;
    logic rst_n;
    wire  miso;

    always #5 clk = ~clk;

    eep_spi_if bus();

    eep_spi_resp #(.INIT_VAL(INIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .MISO  (miso)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_rdy  = 0;
    bit chk_en = 1'b0;

    logic [7:0]  m_mem [64];
    logic [15:0] m_resp;
    logic [15:0] exp_rx;
    logic        exp_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = INIT;
        m_resp  = 16'h0000;
        exp_rx  = 16'h0000;
        exp_rdy = 1'b0;
    endfunction

    function automatic void model_exec(input logic [15:0] w);
        int a;
        a      = int'(w[13:8]);
        exp_rx = w;
        case (w[15:14])
            2'b01:   begin m_mem[a] = w[7:0]; m_resp = 16'h0000; end
            2'b00:   m_resp = {8'h00, m_mem[a]};
            default: m_resp = 16'h0000;
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("frm_rdy", {31'd0, bus.frm_rdy}, {31'd0, exp_rdy});
            check("rx_data", {16'd0, bus.rx_data}, {16'd0, exp_rx});
            if (bus.frm_rdy === 1'b1) n_rdy++;
        end
    end

    task automatic frame(input logic [15:0] w, input int nbits, input int rst_bit,
                         output logic [15:0] got);
        logic [15:0] exp_miso, mask;
        bit          aborted;
        exp_miso = m_resp;
        mask     = 16'hFFFF << (16 - nbits);
        got      = 16'h0000;
        aborted  = 1'b0;
        @(negedge clk);
        bus.EEP_ss_n = 1'b0;
        bus.MOSI     = w[15];
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = w[15-i];
            if (i == rst_bit) begin
                rst_n = 1'b0;
                model_reset();
                aborted = 1'b1;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
            repeat (5) @(negedge clk);
            got[15-i] = miso;
            bus.SCLK = 1'b1;
            repeat (5) @(negedge clk);
            bus.SCLK = 1'b0;
        end
        repeat (5) @(negedge clk);
        bus.EEP_ss_n = 1'b1;
        repeat (3) @(negedge clk);
        if (nbits == 16 && !aborted) begin
            model_exec(w);
            exp_rdy = 1'b1;
            @(negedge clk);
            exp_rdy = 1'b0;
        end
        repeat (6) @(negedge clk);
        if (!aborted) check("miso_frame", {16'd0, got & mask}, {16'd0, exp_miso & mask});
    endtask

    logic [15:0] g;
    int          rdy_before;

    initial begin
        rst_n        = 1'b0;
        bus.SCLK     = 1'b0;
        bus.MOSI     = 1'b0;
        bus.EEP_ss_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_rx_data", {16'd0, bus.rx_data}, 32'h0);
        check("reset_frm_rdy", {31'd0, bus.frm_rdy}, 32'h0);
        chk_en = 1'b1;

        frame(16'h1C00, 16, -1, g);
        frame(16'h1C00, 16, -1, g);
        check("rd_init_miso", {16'd0, g}, 32'h0000);
        check("rd_init_rx", {16'd0, bus.rx_data}, 32'h1C00);
        check("rd_init_pulses", n_rdy, 2);

        frame(16'h5CEF, 16, -1, g);
        frame(16'h1C00, 16, -1, g);
        frame(16'h1C00, 16, -1, g);
        check("rd_1c_miso", {16'd0, g}, 32'h00EF);
        check("mem_1c", {24'd0, dut.mem_q[6'h1C]}, 32'hEF);

        frame(16'h7F5A, 16, -1, g);
        frame(16'h3F00, 16, -1, g);
        frame(16'h3F00, 16, -1, g);
        check("rd_3f_miso", {16'd0, g}, 32'h005A);
        check("mem_00", {24'd0, dut.mem_q[6'h00]}, {24'd0, INIT});

        rdy_before = n_rdy;
        frame(16'h4133, 8, -1, g);
        check("abort_pulses", n_rdy, rdy_before);
        check("abort_mem_01", {24'd0, dut.mem_q[6'h01]}, {24'd0, INIT});
        check("abort_rx", {16'd0, bus.rx_data}, 32'h3F00);
        frame(16'h3F00, 16, -1, g);
        check("after_abort_miso", {16'd0, g}, 32'h005A);

        frame(16'h1C00, 16, -1, g);
        frame(16'hDCAA, 16, -1, g);
        check("unk_op_miso", {16'd0, g}, 32'h00EF);
        frame(16'h1C00, 16, -1, g);
        check("after_unk_miso", {16'd0, g}, 32'h0000);
        check("unk_no_write", {24'd0, dut.mem_q[6'h1C]}, 32'hEF);

        rdy_before = n_rdy;
        frame(16'h1C00, 16, 6, g);
        check("rst_mid_pulses", n_rdy, rdy_before);
        check("rst_mid_rx", {16'd0, bus.rx_data}, 32'h0000);
        frame(16'h1C00, 16, -1, g);
        frame(16'h1C00, 16, -1, g);
        check("rst_rd_miso", {16'd0, g}, {24'd0, INIT});
        check("rst_rd_rx", {16'd0, bus.rx_data}, 32'h1C00);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
